md5_mem_bridge: RTL and testbench
=================================

# md5_mem_bridge

Memory-side companion of the HLS `md5` core. It owns the core's two-channel memory port: serves message-block reads from a loadable 16-word buffer, captures the four digest words the core writes, and sequences one hash run per `go` request. It sits directly beside `md5` in the top level, replacing ad-hoc read/write glue, and exposes digest, match and error status to LEDs or logic-analyzer logic.

## Interface
Parameters:
- `MSG_BASE`, 32'h40000000, byte base of message buffer (drive the core's first pointer with it)
- `DIGEST_BASE`, 32'h40000100, byte base of digest region (second pointer)

Ports:
- `clk`  in  1  single clock domain
- `reset`  in  1  asynchronous, active-low reset
- `go`  in  1  request a hash run; sampled only in IDLE
- `busy`  out  1  high from go accepted until back in IDLE
- `load_we`  in  1  message buffer write strobe (honoured only in IDLE)
- `load_addr`  in  4  message word index
- `load_data`  in  32  message word
- `expected_digest`  in  128  reference digest, word k at [32k+31:32k]
- `start_port`  out  1  to core start
- `done_port`  in  1  from core done
- `Mout_oe_ram`  in  2  per-channel read enable (bit ch = channel ch)
- `Mout_we_ram`  in  2  per-channel write enable
- `Mout_addr_ram`  in  64  channel ch byte address at [32ch+31:32ch]
- `Mout_Wdata_ram`  in  64  channel ch write data, same packing
- `Mout_data_ram_size`  in  12  channel ch access size in bits at [6ch+5:6ch]
- `M_Rdata_ram`  out  64  channel ch read data
- `M_DataRdy`  out  2  per-channel access acknowledge
- `digest`  out  128  captured digest, word k from DIGEST_BASE+4k
- `digest_valid`  out  1  all four digest words written in last run
- `match`  out  1  digest_valid and digest == expected_digest
- `err`  out  1  sticky protocol error for current run
- `cycles`  out  32  run length in clk cycles, saturating

## Operation
- FSM states IDLE -> START -> RUN -> DONE -> IDLE.
- IDLE: `go`=1 -> START; clears `digest`, write mask, `digest_valid`, `match`, `err`, `cycles`. `load_we` writes `mem[load_addr]`.
- START: `start_port`=1 for exactly this cycle; -> RUN.
- RUN: `done_port`=1 -> DONE. `go`, `load_we` ignored.
- DONE: `digest_valid` <= &mask; `match` <= &mask && digest==expected_digest; `err` set if mask incomplete; -> IDLE.
- Per-channel decode: off = addr_ch - base. Hit when off < 64 (message) or off < 16 (digest) and off[1:0]==0.
- Read (oe[ch] in RUN): message hit -> mem[off[5:2]], else 0. Miss, misalignment, or size != 32 -> `err`.
- Write (we[ch] in RUN): digest hit -> digest word off[3:2] <= wdata_ch, mask bit set. Other addresses: no store, `err`.
- oe and we both set on one channel: treat as write, set `err`.
- Both channels write the same digest word in one cycle: channel 1 wins.
- Any oe/we outside RUN: no effect, no ack.
- Message buffer is not reset; all other state is.

## Timing
- Reset values: `busy`, `start_port`, `M_Rdata_ram`, `M_DataRdy`, `digest`, `digest_valid`, `match`, `err`, `cycles` all 0; FSM IDLE.
- Reset mid-run: everything returns to IDLE/zero immediately; a later `done_port` is ignored.
- Read latency 1: `M_Rdata_ram` lane and `M_DataRdy[ch]` registered on the cycle after oe[ch]; rdata lane 0 otherwise.
- Write ack: `M_DataRdy[ch]`=1 the cycle after we[ch]; digest word visible on `digest` that same cycle.
- `busy` rises the cycle after `go` is sampled and falls on entry to IDLE.
- `cycles` increments each cycle in START and RUN, including the cycle `done_port` is seen; saturates at 32'hFFFFFFFF.
- Status outputs are valid from the first IDLE cycle after DONE and hold until the next accepted `go`.

## Test plan
- Load word0=32'h00000080, words1-15=0; pulse `go`. Model core reads MSG_BASE and writes d98c1dd4, 04b2008f, 980980e9, 7e42f8ec to DIGEST_BASE+0/4/8/C. Set expected {7e42f8ec,980980e9,04b2008f,d98c1dd4} -> digest_valid=1, match=1, err=0.
- Read MSG_BASE+4 on ch0 and MSG_BASE+0 on ch1 in the same cycle -> next cycle rdata = {00000080, load word1}, DataRdy=2'b11.
- Only three digest words written before done_port -> digest_valid=0, match=0, err=1.
- Write DIGEST_BASE+2, or read with size=16 -> err=1, no digest update.
- Assert reset low during RUN, then pulse done_port -> all outputs 0, FSM stays IDLE.
- Hold done_port low for 2^32+ cycles (force counter near max) -> cycles saturates at FFFFFFFF; `go` during RUN ignored.

Source files
------------

// File: rtl/md5_mem_bridge.sv
// Memory-side companion of the md5 core: serves message reads from a loadable
// 16-word buffer, captures the digest writes and sequences one run per go.
module md5_mem_bridge #(
  parameter logic [31:0] MSG_BASE    = 32'h40000000,
  parameter logic [31:0] DIGEST_BASE = 32'h40000100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  output logic          busy,
  input  logic          load_we,
  input  logic [3:0]    load_addr,
  input  logic [31:0]   load_data,
  input  logic [127:0]  expected_digest,
  output logic          start_port,
  input  logic          done_port,
  input  logic [1:0]    Mout_oe_ram,
  input  logic [1:0]    Mout_we_ram,
  input  logic [63:0]   Mout_addr_ram,
  input  logic [63:0]   Mout_Wdata_ram,
  input  logic [11:0]   Mout_data_ram_size,
  output logic [63:0]   M_Rdata_ram,
  output logic [1:0]    M_DataRdy,
  output logic [127:0]  digest,
  output logic          digest_valid,
  output logic          match,
  output logic          err,
  output logic [31:0]   cycles
);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t           state_reg;
  logic [3:0]       mask_reg;
  logic [31:0]      mem [16];
  logic [31:0]      cycles_next;

  logic [1:0]       msg_hit;
  logic [1:0]       dig_hit;
  logic [1:0]       ch_err;
  logic [1:0][3:0]  msg_idx;
  logic [1:0][1:0]  dig_idx;

  // Per-channel address decode relative to the two windows.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      logic [31:0] addr;
      logic [31:0] msg_off;
      logic [31:0] dig_off;
      logic        rd_only;
      logic        size_ok;

      assign addr         = Mout_addr_ram[32*gi +: 32];
      assign msg_off      = addr - MSG_BASE;
      assign dig_off      = addr - DIGEST_BASE;
      assign msg_hit[gi]  = (msg_off < 32'd64) && (msg_off[1:0] == 2'b00);
      assign dig_hit[gi]  = (dig_off < 32'd16) && (dig_off[1:0] == 2'b00);
      assign msg_idx[gi]  = msg_off[5:2];
      assign dig_idx[gi]  = dig_off[3:2];
      assign rd_only      = Mout_oe_ram[gi] & ~Mout_we_ram[gi];
      assign size_ok      = (Mout_data_ram_size[6*gi +: 6] == 6'd32);
      // A combined oe+we access is serviced as a write but still flagged.
      assign ch_err[gi]   = (Mout_we_ram[gi] & ~dig_hit[gi])
                          | (Mout_we_ram[gi] & Mout_oe_ram[gi])
                          | (rd_only & (~msg_hit[gi] | ~size_ok));
    end
  endgenerate

  assign cycles_next = (cycles == 32'hFFFFFFFF) ? cycles : cycles + 32'd1;

  // Message buffer is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && load_we)
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      mask_reg     <= '0;
      busy         <= 1'b0;
      start_port   <= 1'b0;
      M_Rdata_ram  <= '0;
      M_DataRdy    <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      match        <= 1'b0;
      err          <= 1'b0;
      cycles       <= '0;
    end else begin
      start_port  <= 1'b0;
      M_Rdata_ram <= '0;
      M_DataRdy   <= '0;
      case (state_reg)
        IDLE: begin
          if (go) begin
            state_reg    <= START;
            busy         <= 1'b1;
            start_port   <= 1'b1;
            mask_reg     <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            match        <= 1'b0;
            err          <= 1'b0;
            cycles       <= '0;
          end
        end
        START: begin
          state_reg <= RUN;
          cycles    <= cycles_next;
        end
        RUN: begin
          cycles <= cycles_next;
          if (done_port)
            state_reg <= DONE;
          // Channel 1 is visited last so it wins a same-word write collision.
          for (int ch = 0; ch < 2; ch++) begin
            if (Mout_oe_ram[ch] || Mout_we_ram[ch])
              M_DataRdy[ch] <= 1'b1;
            if (Mout_we_ram[ch]) begin
              if (dig_hit[ch]) begin
                digest[{dig_idx[ch], 5'b00000} +: 32] <= Mout_Wdata_ram[32*ch +: 32];
                mask_reg[dig_idx[ch]]                 <= 1'b1;
              end
            end else if (Mout_oe_ram[ch] && msg_hit[ch]) begin
              M_Rdata_ram[32*ch +: 32] <= mem[msg_idx[ch]];
            end
            if (ch_err[ch])
              err <= 1'b1;
          end
        end
        DONE: begin
          state_reg    <= IDLE;
          busy         <= 1'b0;
          digest_valid <= &mask_reg;
          match        <= (&mask_reg) && (digest == expected_digest);
          if (!(&mask_reg))
            err <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_mem_bridge.sv
// Directed bench for md5_mem_bridge: a hand-driven core model issues reads,
// digest writes and done pulses; expectations are hand-computed constants.
module tb_md5_mem_bridge;
  localparam logic [31:0] MSG = 32'h40000000;
  localparam logic [31:0] DIG = 32'h40000100;
  localparam logic [127:0] REF = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic          busy;
  logic          load_we = 1'b0;
  logic [3:0]    load_addr = '0;
  logic [31:0]   load_data = '0;
  logic [127:0]  expected_digest = REF;
  logic          start_port;
  logic          done_port = 1'b0;
  logic [1:0]    oe = '0;
  logic [1:0]    we = '0;
  logic [63:0]   addr = '0;
  logic [63:0]   wdata = '0;
  logic [11:0]   size = {6'd32, 6'd32};
  logic [63:0]   rdata;
  logic [1:0]    rdy;
  logic [127:0]  digest;
  logic          digest_valid;
  logic          match;
  logic          err;
  logic [31:0]   cycles;

  int n_checks = 0;
  int n_pass = 0;

  md5_mem_bridge dut (
    .clk                (clk),
    .reset              (reset),
    .go                 (go),
    .busy               (busy),
    .load_we            (load_we),
    .load_addr          (load_addr),
    .load_data          (load_data),
    .expected_digest    (expected_digest),
    .start_port         (start_port),
    .done_port          (done_port),
    .Mout_oe_ram        (oe),
    .Mout_we_ram        (we),
    .Mout_addr_ram      (addr),
    .Mout_Wdata_ram     (wdata),
    .Mout_data_ram_size (size),
    .M_Rdata_ram        (rdata),
    .M_DataRdy          (rdy),
    .digest             (digest),
    .digest_valid       (digest_valid),
    .match              (match),
    .err                (err),
    .cycles             (cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic acc(input logic [1:0] o, input logic [1:0] w,
                     input logic [31:0] a1, input logic [31:0] a0,
                     input logic [31:0] d1, input logic [31:0] d0);
    oe = o; we = w; addr = {a1, a0}; wdata = {d1, d0};
  endtask

  task automatic idle_bus();
    oe = '0; we = '0; addr = '0; wdata = '0; size = {6'd32, 6'd32};
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick();
    load_we = 1'b0;
  endtask

  // Pulse go and leave the DUT at the first RUN cycle.
  task automatic begin_run();
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
  endtask

  task automatic finish_run();
    idle_bus();
    done_port = 1'b1;
    tick();
    done_port = 1'b0;
    tick();
  endtask

  task automatic show_status(input string name);
    $display("%s: digest=%h valid=%0b match=%0b err=%0b cycles=%0d",
             name, digest, digest_valid, match, err, cycles);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_start", start_port, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rdy", rdy, 0);
    check("rst_status", {digest_valid, match, err}, 3'b000);
    check("rst_digest", digest, 0);
    check("rst_cycles", cycles, 0);
    reset = 1'b1;
    tick();

    load(4'd0, 32'h00000080);
    for (int i = 1; i < 16; i++) load(4'(i), 32'h0);

    // Accesses outside RUN are not acknowledged
    acc(2'b11, 2'b00, MSG, MSG, 0, 0);
    tick();
    check("idle_no_ack", rdy, 2'b00);
    check("idle_no_data", rdata, 0);
    idle_bus();

    // Run 1: complete, matching digest
    go = 1'b1;
    tick();
    go = 1'b0;
    check("start_pulse", start_port, 1);
    check("busy_rise", busy, 1);
    tick();
    check("start_once", start_port, 0);
    check("cycles_start", cycles, 1);
    acc(2'b11, 2'b00, MSG + 32'd0, MSG + 32'd4, 0, 0);
    tick();
    check("dual_read_data", rdata, {32'h00000080, 32'h00000000});
    check("dual_read_rdy", rdy, 2'b11);
    acc(2'b00, 2'b11, DIG + 32'd4, DIG + 32'd0, 32'h04b2008f, 32'hd98c1dd4);
    tick();
    check("write_rdy", rdy, 2'b11);
    check("write_no_rdata", rdata, 0);
    check("digest_lo", digest[63:0], {32'h04b2008f, 32'hd98c1dd4});
    acc(2'b00, 2'b11, DIG + 32'd12, DIG + 32'd8, 32'h7e42f8ec, 32'h980980e9);
    tick();
    check("digest_full", digest, REF);
    idle_bus();
    done_port = 1'b1;
    tick();
    done_port = 1'b0;
    check("busy_in_done", busy, 1);
    tick();
    check("run1_busy", busy, 0);
    check("run1_status", {digest_valid, match, err}, 3'b110);
    check("run1_cycles", cycles, 5);
    show_status("run1");

    // Run 2: load ignored in RUN, ch1 wins collision, one word missing
    load(4'd1, 32'h12345678);
    begin_run();
    load_we = 1'b1; load_addr = 4'd1; load_data = 32'hDEADBEEF;
    tick();
    load_we = 1'b0;
    acc(2'b01, 2'b00, 0, MSG + 32'd4, 0, 0);
    tick();
    check("read_word1", rdata, {32'h0, 32'h12345678});
    check("read_ch0_rdy", rdy, 2'b01);
    check("read_ok_err", err, 0);
    acc(2'b00, 2'b11, DIG, DIG, 32'h22222222, 32'h11111111);
    tick();
    check("ch1_wins", digest[31:0], 32'h22222222);
    acc(2'b00, 2'b11, DIG + 32'd8, DIG + 32'd4, 32'h33333333, 32'h44444444);
    tick();
    finish_run();
    check("run2_status", {digest_valid, match, err}, 3'b001);
    check("run2_digest", digest, {32'h0, 32'h33333333, 32'h44444444, 32'h22222222});
    show_status("run2");

    // Run 3: misaligned digest write, then full but wrong digest
    begin_run();
    check("run3_err_clear", err, 0);
    check("run3_digest_clear", digest, 0);
    acc(2'b00, 2'b01, 0, DIG + 32'd2, 0, 32'hFFFFFFFF);
    tick();
    check("misalign_err", err, 1);
    check("misalign_no_store", digest, 0);
    check("misalign_rdy", rdy, 2'b01);
    acc(2'b00, 2'b11, DIG + 32'd4, DIG + 32'd0, 32'hB, 32'hA);
    tick();
    acc(2'b00, 2'b11, DIG + 32'd12, DIG + 32'd8, 32'hD, 32'hC);
    tick();
    finish_run();
    check("run3_status", {digest_valid, match, err}, 3'b101);
    show_status("run3");

    // Run 4: 16-bit read is flagged
    begin_run();
    check("run4_err_clear", err, 0);
    size = {6'd32, 6'd16};
    acc(2'b01, 2'b00, 0, MSG, 0, 0);
    tick();
    check("size16_err", err, 1);
    check("size16_digest", digest, 0);
    finish_run();
    check("run4_status", {digest_valid, match, err}, 3'b001);

    // Reset in the middle of a run
    begin_run();
    acc(2'b00, 2'b01, 0, DIG, 0, 32'h55555555);
    tick();
    #1 reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_outs", {rdy, rdata, start_port}, 0);
    check("midrst_status", {digest, digest_valid, match, err}, 0);
    check("midrst_cycles", cycles, 0);
    idle_bus();
    tick();
    reset = 1'b1;
    tick();
    done_port = 1'b1;
    tick();
    done_port = 1'b0;
    tick();
    check("post_rst_idle", {busy, start_port, digest_valid, match, err}, 0);
    check("post_rst_cycles", cycles, 0);

    // Cycle counter saturation; go in RUN has no effect
    begin_run();
    force dut.cycles = 32'hFFFFFFFD;
    go = 1'b1;
    tick();
    release dut.cycles;
    tick();
    check("sat_step", cycles, 32'hFFFFFFFE);
    check("go_in_run", {busy, start_port}, 2'b10);
    tick();
    tick();
    go = 1'b0;
    check("sat_hold", cycles, 32'hFFFFFFFF);
    finish_run();
    check("sat_final", cycles, 32'hFFFFFFFF);
    check("sat_busy", busy, 0);
    show_status("run_sat");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
